// File: rtl/cnt_seq_ctrl.sv
// Sequencer for a WIDTH-bit up-counter with one-shot / auto-reload modes; optional prescaler via CNT_PRESCALE_EN.
// Latency: terminal edge lands limit+1 edges after accept ((limit+1)*PRESCALE with the prescaler); done/tick are registered.
// Backpressure: cmd_ready is low in RUN and whenever abort is high; the host holds the command until accepted.

module cnt_adder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   assign {cout, sum} = {1'b0, a} + {{WIDTH{1'b0}}, cin};
endmodule

module cnt_datapath #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             adv,
   output logic [WIDTH-1:0] cnt
);
   logic [WIDTH-1:0] sum;
   // The sequencer never advances past the limit, so the carry-out can be ignored.
   logic             unused_cout;

   cnt_adder #(.WIDTH(WIDTH)) u_adder (
      .a    (cnt),
      .cin  (1'b1),
      .sum  (sum),
      .cout (unused_cout)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (adv)
         cnt <= sum;
   end
endmodule

module cnt_seq_ctrl #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_limit,
   input  logic             cmd_reload,
   input  logic             hold,
   input  logic             abort,
   output logic [WIDTH-1:0] cnt,
   output logic             busy,
   output logic             done,
   output logic             tick,
   output logic [WIDTH-1:0] wraps
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] limit_q;
   logic             mode_q;
   logic             accept;
   logic             step;
   logic             cnt_clr, cnt_adv;
   logic             done_d, tick_d, wraps_inc;

   assign cmd_ready = ((state_q == S_IDLE) || (state_q == S_DONE)) && !abort;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state_q == S_RUN);

`ifdef CNT_PRESCALE_EN
   localparam int PW = $clog2(PRESCALE);
   logic [PW-1:0] presc_q;

   assign step = (presc_q == PW'(PRESCALE - 1));

   // Runs only in RUN; frozen by hold, cleared on abort and whenever RUN is (re)entered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         presc_q <= '0;
      else if ((state_q != S_RUN) || abort)
         presc_q <= '0;
      else if (!hold)
         presc_q <= step ? '0 : presc_q + 1'b1;
   end
`else
   logic [4:0] unused_prescale;
   assign unused_prescale = 5'(PRESCALE);
   assign step = 1'b1;
`endif

   cnt_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .adv (cnt_adv),
      .cnt (cnt)
   );

   always_comb begin
      state_d   = state_q;
      cnt_clr   = 1'b0;
      cnt_adv   = 1'b0;
      done_d    = 1'b0;
      tick_d    = 1'b0;
      wraps_inc = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_RUN;
               cnt_clr = 1'b1;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               cnt_clr = 1'b1;
            end else if (hold) begin
               state_d = S_RUN;
            end else if (step) begin
               if (cnt != limit_q) begin
                  cnt_adv = 1'b1;
               end else if (!mode_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  cnt_clr   = 1'b1;
                  tick_d    = 1'b1;
                  wraps_inc = 1'b1;
               end
            end
         end
         S_DONE: begin
            // accept already excludes abort, so abort wins over a same-cycle command.
            if (abort) begin
               state_d = S_IDLE;
               cnt_clr = 1'b1;
            end else if (accept) begin
               state_d = S_RUN;
               cnt_clr = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_clr = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         limit_q <= '0;
         mode_q  <= 1'b0;
         done    <= 1'b0;
         tick    <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= done_d;
         tick    <= tick_d;
         if (accept) begin
            limit_q <= cmd_limit;
            mode_q  <= cmd_reload;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         wraps <= '0;
      else if (accept)
         wraps <= '0;
      else if (wraps_inc && (wraps != {WIDTH{1'b1}}))
         wraps <= wraps + 1'b1;
   end
endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl; default build, or prescaler scenario when CNT_PRESCALE_EN is defined.
module tb_cnt_seq_ctrl;
   localparam int WIDTH    = 4;
   localparam int PRESCALE = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid, cmd_ready, cmd_reload, hold, abort;
   logic [WIDTH-1:0] cmd_limit;
   logic [WIDTH-1:0] cnt, wraps;
   logic             busy, done, tick;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cnt_seq_ctrl #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_limit  (cmd_limit),
      .cmd_reload (cmd_reload),
      .hold       (hold),
      .abort      (abort),
      .cnt        (cnt),
      .busy       (busy),
      .done       (done),
      .tick       (tick),
      .wraps      (wraps)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_cmd(input logic [WIDTH-1:0] lim, input logic rl);
      cmd_valid  = 1'b1;
      cmd_limit  = lim;
      cmd_reload = rl;
      cyc();
      cmd_valid  = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d expected 0", cnt); end
      checks++; if ({busy, done, tick} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", {busy, done, tick}); end
      checks++; if (wraps !== 4'd0) begin errors++; $display("FAIL reset_wraps got %0d expected 0", wraps); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", cmd_ready); end
      rst = 1'b1;
      cyc();
      start_cmd(4'd9, 1'b0);
      repeat (5) cyc();
      checks++; if (cnt !== 4'd5) begin errors++; $display("FAIL midrun_cnt got %0d expected 5", cnt); end
      #2 rst = 1'b0;
      #1;
      checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL async_reset_cnt got %0d expected 0", cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b expected 0", busy); end
      cyc();
      checks++; if ({done, tick} !== 2'b00) begin errors++; $display("FAIL reset_no_pulse got %b expected 00", {done, tick}); end
      rst = 1'b1;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b expected 1", cmd_ready); end
   endtask

   task automatic test_oneshot();
      start_cmd(4'd3, 1'b0);
      checks++; if ({busy, cnt} !== {1'b1, 4'd0}) begin errors++; $display("FAIL os_accept got busy=%b cnt=%0d expected busy=1 cnt=0", busy, cnt); end
      for (int i = 1; i <= 3; i++) begin
         cyc();
         checks++; if ({done, cnt} !== {1'b0, 4'(i)}) begin errors++; $display("FAIL os_count got done=%b cnt=%0d expected done=0 cnt=%0d", done, cnt, i); end
      end
      cyc();
      checks++; if ({done, busy, cnt} !== {1'b1, 1'b0, 4'd3}) begin errors++; $display("FAIL os_done got done=%b busy=%b cnt=%0d expected 1 0 3", done, busy, cnt); end
      cyc();
      checks++; if ({done, cnt, cmd_ready} !== {1'b0, 4'd3, 1'b1}) begin errors++; $display("FAIL os_after got done=%b cnt=%0d rdy=%b expected 0 3 1", done, cnt, cmd_ready); end
   endtask

   task automatic test_autoreload();
      logic [3:0] exp_cnt  [8] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};
      logic       exp_tick [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [3:0] exp_wr   [8] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2};
      start_cmd(4'd2, 1'b1);
      checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL ar_accept got cnt=%0d expected 0", cnt); end
      for (int i = 0; i < 8; i++) begin
         cyc();
         checks++;
         if ({cnt, tick, wraps, done, busy} !== {exp_cnt[i], exp_tick[i], exp_wr[i], 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ar_step%0d got cnt=%0d tick=%b wraps=%0d done=%b busy=%b expected cnt=%0d tick=%b wraps=%0d done=0 busy=1",
                     i, cnt, tick, wraps, done, busy, exp_cnt[i], exp_tick[i], exp_wr[i]);
         end
      end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ar_ready_run got %b expected 0", cmd_ready); end
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      checks++; if ({busy, cnt, tick, wraps} !== {1'b0, 4'd0, 1'b0, 4'd2}) begin errors++; $display("FAIL ar_abort got busy=%b cnt=%0d tick=%b wraps=%0d expected 0 0 0 2", busy, cnt, tick, wraps); end
   endtask

   task automatic test_hold();
      start_cmd(4'd4, 1'b0);
      checks++; if (wraps !== 4'd0) begin errors++; $display("FAIL hold_wraps_clr got %0d expected 0", wraps); end
      cyc();
      hold = 1'b1;
      cyc();
      checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL hold_1 got cnt=%0d expected 1", cnt); end
      cyc();
      hold = 1'b0;
      checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL hold_2 got cnt=%0d expected 1", cnt); end
      for (int e = 4; e <= 6; e++) begin
         cyc();
         checks++; if ({done, cnt} !== {1'b0, 4'(e - 2)}) begin errors++; $display("FAIL hold_edge%0d got done=%b cnt=%0d expected done=0 cnt=%0d", e, done, cnt, e - 2); end
      end
      cyc();
      checks++; if ({done, cnt} !== {1'b1, 4'd4}) begin errors++; $display("FAIL hold_done got done=%b cnt=%0d expected 1 4", done, cnt); end
   endtask

   task automatic test_abort();
      start_cmd(4'd5, 1'b0);
      cyc();
      cyc();
      checks++; if (cnt !== 4'd2) begin errors++; $display("FAIL ab_pre got cnt=%0d expected 2", cnt); end
      abort      = 1'b1;
      cmd_valid  = 1'b1;
      cmd_limit  = 4'd3;
      cmd_reload = 1'b0;
      #1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ab_ready got %b expected 0", cmd_ready); end
      cyc();
      checks++; if ({busy, cnt, done} !== {1'b0, 4'd0, 1'b0}) begin errors++; $display("FAIL ab_idle got busy=%b cnt=%0d done=%b expected 0 0 0", busy, cnt, done); end
      cyc();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_idle_abort got busy=%b expected 0", busy); end
      abort = 1'b0;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ab_ready_again got %b expected 1", cmd_ready); end
      cyc();
      cmd_valid = 1'b0;
      checks++; if ({busy, cnt} !== {1'b1, 4'd0}) begin errors++; $display("FAIL ab_accept got busy=%b cnt=%0d expected 1 0", busy, cnt); end
      repeat (3) cyc();
      checks++; if ({cnt, done} !== {4'd3, 1'b0}) begin errors++; $display("FAIL ab_new_limit got cnt=%0d done=%b expected 3 0", cnt, done); end
      cyc();
      checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL ab_new_done got done=%b busy=%b expected 1 0", done, busy); end
   endtask

   task automatic test_limit_max();
      start_cmd(4'd15, 1'b0);
      for (int i = 1; i <= 15; i++) begin
         cyc();
         checks++; if ({cnt, done} !== {4'(i), 1'b0}) begin errors++; $display("FAIL max_count got cnt=%0d done=%b expected cnt=%0d done=0", cnt, done, i); end
      end
      cyc();
      checks++; if ({done, cnt, busy} !== {1'b1, 4'd15, 1'b0}) begin errors++; $display("FAIL max_done got done=%b cnt=%0d busy=%b expected 1 15 0", done, cnt, busy); end
      start_cmd(4'd0, 1'b0);
      checks++; if ({busy, cnt, done} !== {1'b1, 4'd0, 1'b0}) begin errors++; $display("FAIL zero_accept got busy=%b cnt=%0d done=%b expected 1 0 0", busy, cnt, done); end
      cyc();
      checks++; if ({done, busy, cnt} !== {1'b1, 1'b0, 4'd0}) begin errors++; $display("FAIL zero_done got done=%b busy=%b cnt=%0d expected 1 0 0", done, busy, cnt); end
      cyc();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_clr got %b expected 0", done); end
   endtask

   task automatic test_prescale();
      start_cmd(4'd1, 1'b0);
      for (int e = 1; e <= 8; e++) begin
         cyc();
         checks++;
         if ({cnt, done} !== {((e >= 4) ? 4'd1 : 4'd0), (e == 8)}) begin
            errors++;
            $display("FAIL presc_edge%0d got cnt=%0d done=%b expected cnt=%0d done=%b", e, cnt, done, (e >= 4) ? 1 : 0, e == 8);
         end
      end
   endtask

   initial begin
      rst        = 1'b0;
      cmd_valid  = 1'b0;
      cmd_limit  = '0;
      cmd_reload = 1'b0;
      hold       = 1'b0;
      abort      = 1'b0;
      test_reset();
`ifdef CNT_PRESCALE_EN
      test_prescale();
`else
      test_oneshot();
      test_autoreload();
      test_hold();
      test_abort();
      test_limit_max();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      errors++;
      $display("FAIL watchdog got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end
endmodule
